// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer for the five-stage pipeline.
// Owns the fetch PC, issues word addresses to a one-cycle synchronous
// instruction memory, and buffers returned words in order. Buffered words
// are handed to decode over a valid/ready handshake. A redirect flushes the
// buffer and squashes the read that is still in flight. Halt blocks new issues.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] mem_addr,
   output logic        mem_en,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
   localparam int CNT_W = 3;
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

   // Fetch-side state
   logic [31:0] fetch_pc;
   logic [31:0] inflight_pc;
   logic        inflight;
   logic        started;

   // Fetch buffer (circular FIFO)
   logic [31:0]      buf_instr [BUF_DEPTH];
   logic [31:0]      buf_pc    [BUF_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   // Per-cycle decisions
   logic [31:0]      redirect_aligned;
   logic [CNT_W-1:0] occupancy;
   logic             pop;
   logic             push;
   logic             credit;
   logic             issue;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Head of the FIFO is presented directly to decode.
   assign out_valid = (count != '0);
   assign out_instr = buf_instr[head];
   assign out_pc    = buf_pc[head];

   // Issue decision and address mux. On a redirect the buffer is about to be
   // flushed and the prior read is squashed, so occupancy counts as zero.
   // Issuing waits one clock after reset release (started).
   always_comb begin
      redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
      pop              = out_valid && out_ready;
      push             = inflight && !redirect_valid;
      occupancy        = '0;
      if (!redirect_valid) begin
         occupancy = count + CNT_W'(inflight) - CNT_W'(pop);
      end
      credit   = (occupancy < DEPTH_CNT);
      issue    = started && credit && !halt;
      mem_addr = redirect_valid ? redirect_aligned : fetch_pc;
      mem_en   = issue;
   end

   // Fetch PC, in-flight read tracking and the post-reset start flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         started     <= 1'b0;
      end else begin
         started  <= 1'b1;
         inflight <= issue;
         if (issue) begin
            inflight_pc <= mem_addr;
            fetch_pc    <= mem_addr + 32'd4;
         end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
         end
      end
   end

   // Fetch buffer: capture returning reads at the tail, pop at the head,
   // and flush everything on a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= '0;
         end
      end else if (redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            buf_instr[tail] <= mem_rdata;
            buf_pc[tail]    <= inflight_pc;
            tail            <= ptr_inc(tail);
         end
         if (pop) begin
            head <= ptr_inc(head);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: directed scenarios with literal expectations
// followed by randomized ready/halt/redirect traffic, all compared every
// cycle against a queue-based behavioural model.
module tb_imem_fetch_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic        mem_en;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int checks = 0;
   int errors = 0;

   imem_fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_addr(mem_addr),
      .mem_en(mem_en),
      .mem_rdata(mem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .halt(halt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory content: word i holds 0x1000_0000 + i.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   // Synchronous one-cycle instruction memory.
   always @(posedge clk) mem_rdata <= mem_word(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: a queue of buffered PCs plus a single in-flight slot.
   logic [31:0] mq[$];
   logic [31:0] m_fpc;
   logic [31:0] m_inf_pc;
   logic        m_inf;
   logic        m_started;

   // Per-cycle compare against the model, then advance the model one clock.
   always @(negedge clk) begin
      logic        e_valid, e_pop, e_issue;
      logic [31:0] e_addr;
      int          occ;
      if (!rst_n) begin
         mq.delete();
         m_fpc     = RESET_PC;
         m_inf     = 1'b0;
         m_inf_pc  = '0;
         m_started = 1'b0;
         chk("rst_mem_en", 32'(mem_en), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_mem_addr", mem_addr, RESET_PC);
         chk("rst_out_pc", out_pc, 32'd0);
         chk("rst_out_instr", out_instr, 32'd0);
      end else begin
         e_valid = (mq.size() > 0);
         e_pop   = e_valid && out_ready;
         occ     = redirect_valid ? 0 : mq.size() + int'(m_inf) - int'(e_pop);
         e_issue = m_started && (occ < BUF_DEPTH) && !halt;
         e_addr  = redirect_valid ? {redirect_pc[31:2], 2'b00} : m_fpc;
         chk("mem_en", 32'(mem_en), 32'(e_issue));
         chk("mem_addr", mem_addr, e_addr);
         chk("out_valid", 32'(out_valid), 32'(e_valid));
         if (e_valid) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_instr", out_instr, mem_word(mq[0]));
         end
         if (e_pop) void'(mq.pop_front());
         if (redirect_valid) mq.delete();
         else if (m_inf) mq.push_back(m_inf_pc);
         chk("overflow", 32'(mq.size() <= BUF_DEPTH), 32'd1);
         m_inf = e_issue;
         if (e_issue) begin
            m_inf_pc = e_addr;
            m_fpc    = e_addr + 32'd4;
         end else if (redirect_valid) begin
            m_fpc = e_addr;
         end
         m_started = 1'b1;
      end
   end

   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b1;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) tick();
      chk("lit_rst_en", 32'(mem_en), 32'd0);
      chk("lit_rst_addr", mem_addr, 32'h0);
      chk("lit_rst_valid", 32'(out_valid), 32'd0);

      // Reset release and streaming start-up.
      rst_n = 1'b1;
      tick();
      chk("lit_first_issue_en", 32'(mem_en), 32'd1);
      chk("lit_first_issue_addr", mem_addr, 32'h0);
      tick();
      chk("lit_second_addr", mem_addr, 32'h4);
      chk("lit_no_valid_yet", 32'(out_valid), 32'd0);
      tick();
      chk("lit_first_valid", 32'(out_valid), 32'd1);
      chk("lit_first_pc", out_pc, 32'h0);
      chk("lit_first_instr", out_instr, 32'h1000_0000);
      tick();
      chk("lit_pc4", out_pc, 32'h4);
      chk("lit_instr1", out_instr, 32'h1000_0001);
      tick();
      chk("lit_pc8", out_pc, 32'h8);
      chk("lit_instr2", out_instr, 32'h1000_0002);

      // Backpressure.
      out_ready = 1'b0;
      repeat (6) tick();
      chk("lit_stall_en", 32'(mem_en), 32'd0);
      chk("lit_stall_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      repeat (4) tick();

      // Redirect while the buffer is full.
      out_ready = 1'b0;
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0043;
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      chk("lit_redir_flushed", 32'(out_valid), 32'd0);
      tick();
      chk("lit_redir_valid", 32'(out_valid), 32'd1);
      chk("lit_redir_pc40", out_pc, 32'h40);
      chk("lit_redir_instr", out_instr, 32'h1000_0010);
      tick();
      chk("lit_redir_pc44", out_pc, 32'h44);

      // Back-to-back redirects.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect_valid = 1'b0;
      chk("lit_b2b_gap", 32'(out_valid), 32'd0);
      tick();
      chk("lit_b2b_pc80", out_pc, 32'h80);
      repeat (3) tick();

      // Halt mid-stream.
      halt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("lit_halt_en", 32'(mem_en), 32'd0);
      end
      halt = 1'b0;
      repeat (5) tick();

      // Address wrap at the top of the space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFB;
      tick();
      redirect_valid = 1'b0;
      tick();
      chk("lit_wrap_f8", out_pc, 32'hFFFF_FFF8);
      tick();
      chk("lit_wrap_fc", out_pc, 32'hFFFF_FFFC);
      tick();
      chk("lit_wrap_0", out_pc, 32'h0);
      chk("lit_wrap_instr", out_instr, 32'h1000_0000);

      // Asynchronous reset in the middle of a cycle with data buffered.
      out_ready = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("lit_async_valid", 32'(out_valid), 32'd0);
      chk("lit_async_en", 32'(mem_en), 32'd0);
      chk("lit_async_addr", mem_addr, RESET_PC);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) break;
         tick();
      end
      chk("lit_restart_valid", 32'(out_valid), 32'd1);
      chk("lit_restart_pc", out_pc, RESET_PC);
      chk("lit_restart_instr", out_instr, 32'h1000_0000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         out_ready      = ($urandom_range(0, 9) < 7);
         halt           = ($urandom_range(0, 11) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         tick();
      end
      redirect_valid = 1'b0;
      halt           = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
